// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared FSM encoding, LFSR taps, display views and symbol helpers for the memory game
package memory_game_pkg;

    localparam int SYM_W = 4;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [2:0] VIEW_CORRECT = 3'd0;
    localparam logic [2:0] VIEW_INCORRECT = 3'd1;
    localparam logic [2:0] VIEW_PERCENT = 3'd2;

    typedef enum logic [2:0] {ST_GEN, ST_SHOW, ST_WAIT, ST_JUDGE, ST_COMMIT} state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [SYM_W-1:0] sym_of(input logic [15:0] l);
        return (l[3:0] < 4'd10) ? l[3:0] : l[3:0] - 4'd10;
    endfunction

endpackage

// File: rtl/memory_key_conditioner.sv
// memory_key_conditioner: 2-flop sync, debounce and single press pulse for an active-low button
module memory_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          fired;
    logic          low;

    assign low   = ~sync[1];
    assign press = low & ~fired & (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // fired holds off further pulses until the synced level goes high again
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync  <= 2'b11;
            cnt   <= '0;
            fired <= 1'b0;
        end else begin
            sync <= {sync[0], key_n};
            if (!low) begin
                cnt   <= '0;
                fired <= 1'b0;
            end else if (press) begin
                fired <= 1'b1;
            end else if (!fired) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/memory_round_judge.sv
// memory_round_judge: round sequencer and seen/new answer judge for the memory game
// Optional answer timeout enabled by defining MEMORY_ROUND_TIMEOUT_EN.
module memory_round_judge
    import memory_game_pkg::*;
#(
    parameter int          DEPTH           = 8,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          TIMEOUT_CYCLES  = 500000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             key_seen_n,
    input  logic             key_new_n,
    input  logic             key_mode_n,
    output logic [SYM_W-1:0] sym_digit,
    output logic             sym_valid,
    output logic             result_valid,
    output logic             result_correct,
    output logic [2:0]       display_state
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || SEED == 16'h0 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("memory_round_judge: illegal parameter value");
    end

    state_t           state, state_nxt;
    logic [15:0]      lfsr;
    logic [SYM_W-1:0] hist [DEPTH];
    logic [DEPTH-1:0] hist_v;
    logic [PW-1:0]    wr_ptr;
    logic             seen_p, new_p, mode_p;
    logic             take, timeout, exists;
    logic             ans_seen, timed_out;

    memory_key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_seen (
        .clk(clk), .resetn(resetn), .key_n(key_seen_n), .press(seen_p)
    );
    memory_key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_new (
        .clk(clk), .resetn(resetn), .key_n(key_new_n), .press(new_p)
    );
    memory_key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .resetn(resetn), .key_n(key_mode_n), .press(mode_p)
    );

    // simultaneous seen and new presses are ambiguous and count as no answer
    assign take = seen_p ^ new_p;

`ifdef MEMORY_ROUND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tmo_cnt <= '0;
        else         tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + TW'(1) : '0;
    end

    assign timeout = (state == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        exists = 1'b0;
        for (int i = 0; i < DEPTH; i++) exists |= hist_v[i] && (hist[i] == sym_digit);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_GEN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_GEN:    state_nxt = ST_SHOW;
            ST_SHOW:   state_nxt = ST_WAIT;
            ST_WAIT:   state_nxt = (take || timeout) ? ST_JUDGE : ST_WAIT;
            ST_JUDGE:  state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_GEN;
            default:   state_nxt = ST_GEN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr           <= SEED;
            sym_digit      <= '0;
            sym_valid      <= 1'b0;
            result_valid   <= 1'b0;
            result_correct <= 1'b0;
            ans_seen       <= 1'b0;
            timed_out      <= 1'b0;
            hist_v         <= '0;
            wr_ptr         <= '0;
        end else begin
            case (state)
                ST_GEN: begin
                    sym_digit <= sym_of(lfsr);
                    lfsr      <= lfsr_step(lfsr);
                end
                ST_SHOW: sym_valid <= 1'b1;
                ST_WAIT: begin
                    ans_seen  <= seen_p;
                    timed_out <= ~take;
                end
                ST_JUDGE: begin
                    result_valid   <= 1'b1;
                    result_correct <= ~timed_out & (ans_seen ? exists : ~exists);
                end
                ST_COMMIT: begin
                    result_valid   <= 1'b0;
                    sym_valid      <= 1'b0;
                    hist_v[wr_ptr] <= 1'b1;
                    wr_ptr         <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // digit storage needs no reset: entries are qualified by hist_v
    always_ff @(posedge clk) begin
        if (state == ST_COMMIT) hist[wr_ptr] <= sym_digit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     display_state <= VIEW_CORRECT;
        else if (mode_p) display_state <= (display_state == VIEW_CORRECT)   ? VIEW_INCORRECT :
                                          (display_state == VIEW_INCORRECT) ? VIEW_PERCENT : VIEW_CORRECT;
    end

endmodule

// File: tb/tb_memory_round_judge.sv
// tb_memory_round_judge: randomized rounds checked against a queue-based model of the memory game
module tb_memory_round_judge;

    localparam int          DEPTH = 4;
    localparam int          DEB   = 4;
    localparam int          TMO   = 20;
    localparam logic [15:0] SEED  = 16'h0003;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_seen_n = 1'b1;
    logic       key_new_n = 1'b1;
    logic       key_mode_n = 1'b1;
    logic [3:0] sym_digit;
    logic       sym_valid, result_valid, result_correct;
    logic [2:0] display_state;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;
    logic rv_last = 1'b0;
    logic rv_prev = 1'b0;

    logic [15:0] m_lfsr;
    int m_hist[$];
    int m_view;

    always #5 clk = ~clk;

    memory_round_judge #(
        .DEPTH(DEPTH), .SEED(SEED), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .key_seen_n(key_seen_n), .key_new_n(key_new_n), .key_mode_n(key_mode_n),
        .sym_digit(sym_digit), .sym_valid(sym_valid),
        .result_valid(result_valid), .result_correct(result_correct),
        .display_state(display_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rv_prev) chk("result_pulse_width", {31'b0, result_valid}, 0);
        if (result_valid) begin
            rv_cnt++;
            rv_last = result_correct;
        end
        rv_prev = result_valid;
    end

    function automatic int m_digit();
        return int'(m_lfsr[3:0]) % 10;
    endfunction

    task automatic m_step();
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    function automatic logic m_exists(input int d);
        foreach (m_hist[i]) if (m_hist[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_commit(input int d);
        m_hist.push_back(d);
        if (m_hist.size() > DEPTH) m_hist.delete(0);
        m_step();
    endtask

    task automatic m_reset();
        m_lfsr = SEED;
        m_hist.delete();
        m_view = 0;
    endtask

    // which: 0 seen, 1 new, 2 mode, 3 seen+new
    task automatic set_keys(input int which, input logic lvl);
        if (which == 0 || which == 3) key_seen_n = lvl;
        if (which == 1 || which == 3) key_new_n = lvl;
        if (which == 2) key_mode_n = lvl;
    endtask

    task automatic hold_low(input int which, input int n);
        set_keys(which, 1'b0);
        repeat (n) @(negedge clk);
        set_keys(which, 1'b1);
    endtask

    task automatic wait_sym();
        for (int i = 0; i < 40 && !sym_valid; i++) @(negedge clk);
        chk("sym_valid_wait", {31'b0, sym_valid}, 1);
    endtask

    task automatic round(input int seen);
        int d, base;
        logic ex;
        wait_sym();
        d = m_digit();
        chk("sym_digit", {28'b0, sym_digit}, d);
        ex = m_exists(d);
        base = rv_cnt;
        set_keys(seen != 0 ? 0 : 1, 1'b0);
        for (int i = 0; i < 40 && rv_cnt == base; i++) begin
            @(negedge clk);
            if (i == DEB + 3) set_keys(seen != 0 ? 0 : 1, 1'b1);
        end
        set_keys(seen != 0 ? 0 : 1, 1'b1);
        repeat (4) @(negedge clk);
        chk("result_count", rv_cnt - base, 1);
        chk("result_correct", {31'b0, rv_last}, (seen != 0) ? ex : !ex);
        m_commit(d);
    endtask

    task automatic mode_press();
        hold_low(2, DEB + 3);
        repeat (4) @(negedge clk);
        m_view = (m_view + 1) % 3;
        chk("display_state", {29'b0, display_state}, m_view);
    endtask

    task automatic check_reset_outputs();
        chk("rst_sym_digit", {28'b0, sym_digit}, 0);
        chk("rst_sym_valid", {31'b0, sym_valid}, 0);
        chk("rst_result_valid", {31'b0, result_valid}, 0);
        chk("rst_result_correct", {31'b0, result_correct}, 0);
        chk("rst_display_state", {29'b0, display_state}, 0);
    endtask

    initial begin
        int base, d;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;

        round(0);
        round(1);

        wait_sym();
        base = rv_cnt;
        hold_low(1, 2);
        repeat (20) @(negedge clk);
        chk("short_press_no_result", rv_cnt - base, 0);
        chk("short_press_still_waiting", {31'b0, sym_valid}, 1);

        hold_low(1, 1);
        @(negedge clk);
        hold_low(1, 2);
        @(negedge clk);
        round(0);

        wait_sym();
        base = rv_cnt;
        hold_low(3, DEB + 6);
        repeat (20) @(negedge clk);
        chk("both_keys_no_result", rv_cnt - base, 0);
        chk("both_keys_still_waiting", {31'b0, sym_valid}, 1);
        round(0);

        repeat (4) mode_press();

        wait_sym();
        d = m_digit();
        chk("tmo_sym_digit", {28'b0, sym_digit}, d);
        base = rv_cnt;
        repeat (TMO + 20) @(negedge clk);
`ifdef MEMORY_ROUND_TIMEOUT_EN
        chk("timeout_result_count", rv_cnt - base, 1);
        chk("timeout_result_correct", {31'b0, rv_last}, 0);
        m_commit(d);
`else
        chk("no_timeout_result", rv_cnt - base, 0);
        round($urandom_range(0, 1));
`endif

        for (int r = 0; r < 25; r++) begin
            round($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) mode_press();
        end

        wait_sym();
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        m_reset();
        round(0);
        round($urandom_range(0, 1));
        mode_press();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_round_judge.md
# memory_round_judge

Round sequencer and answer judge for the memory game. Each round it draws a decimal symbol, shows it to the player and waits for a "seen before" or "new" key press. It compares the answer against a short history of earlier symbols and emits a one-cycle scored result. It is the producer of the key-event, correctness and display-view signals that the score/display controller consumes.

## Interface
- DEPTH, 8: history entries remembered (2..16)
- SEED, 16'hACE1: LFSR reset value, must be nonzero
- DEBOUNCE_CYCLES, 16: consecutive stable-low cycles to accept a press (≥1)
- TIMEOUT_CYCLES, 500000: answer window, used only with timeout compiled in

- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- key_seen_n  in  1  async push-button, low = player claims "seen before"
- key_new_n  in  1  async push-button, low = player claims "new"
- key_mode_n  in  1  async push-button, low = advance display view
- sym_digit  out  4  current symbol 0..9
- sym_valid  out  1  high while a symbol is awaiting an answer
- result_valid  out  1  one-cycle pulse per judged round
- result_correct  out  1  answer correctness, valid with result_valid
- display_state  out  3  display view select 0/1/2

## Operation
- Key conditioning, per key: 2-flop synchronizer, then debounce counter. A press pulse (1 cycle) fires when the synced level has been low for DEBOUNCE_CYCLES consecutive cycles. Re-arm only after the synced level returns high. Exactly one pulse per physical press.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset to SEED. Symbol map: v = lfsr[3:0]; digit = v<10 ? v : v-10. LFSR shifts once per GEN.
- FSM states:
  - GEN: latch digit from current LFSR into sym_digit, shift LFSR → SHOW
  - SHOW: sym_valid←1 → WAIT
  - WAIT: on exactly one of seen/new pulses → JUDGE. Both pulses in the same cycle are ignored and the FSM stays in WAIT.
  - JUDGE: exists = any valid history entry equals sym_digit. result_correct = (seen & exists) | (new & ~exists), result_valid←1 → COMMIT.
  - COMMIT: result_valid←0, sym_valid←0, write sym_digit at wr_ptr, set its valid bit, wr_ptr wraps DEPTH-1→0 overwriting oldest → GEN
- The history comparison uses the contents before the current symbol is inserted.
- Seen/new pulses outside WAIT are discarded, not queued.
- Mode pulse in any state: display_state 0→1→2→0, independent of the FSM.
- Reset (any time, mid-round included):
  - FSM→GEN, all history valid bits 0, wr_ptr 0, LFSR=SEED, debouncers cleared
  - sym_digit 0, sym_valid 0, result_valid 0, result_correct 0, display_state 0

## Timing
- Press latency: 2 sync cycles + DEBOUNCE_CYCLES to pulse. result_valid is asserted the cycle after the FSM enters JUDGE and lasts exactly 1 cycle.
- Round turnaround after judging: COMMIT→GEN→SHOW = 3 cycles until sym_valid re-asserts with the new digit.
- After reset release: GEN on the first clk, sym_valid high on the second cycle.
- sym_digit is stable from GEN through COMMIT.
- At most one result per round.

## Configuration
- MEMORY_ROUND_TIMEOUT_EN defined:
  - a counter runs while in WAIT
  - reaching TIMEOUT_CYCLES forces JUDGE with result_correct=0, then normal COMMIT
  - the counter clears on entry to WAIT
- Undefined: WAIT holds indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Shared package memory_game_pkg: FSM state encoding, LFSR tap mask, display view constants (VIEW_CORRECT=0, VIEW_INCORRECT=1, VIEW_PERCENT=2), symbol width.
- Sub-module memory_key_conditioner (synchronizer + debounce + press pulse), instantiated three times.
- History buffer and parallel compare stay inline.

## Test plan
- SEED=16'h0003, DEBOUNCE_CYCLES=4: reset, first symbol → sym_digit=3; press new → result_valid 1 cycle, result_correct=1.
- Force a repeated digit (choose SEED so round k repeats an earlier digit within DEPTH): press seen → correct=1; repeat with new → correct=0.
- Press shorter than DEBOUNCE_CYCLES, then a 3-bounce press → no pulse for the first, exactly one result for the second.
- Seen and new asserted together → no result, FSM stays in WAIT; then new alone → one result.
- DEPTH=2: three distinct rounds, then the first digit reappears → exists=0, so new is correct (entry overwritten).
- Assert resetn low mid-WAIT → all outputs at reset values, history cleared, next symbol equals the first post-SEED symbol. With MEMORY_ROUND_TIMEOUT_EN and TIMEOUT_CYCLES=20, no press → result_valid with correct=0 after 20 WAIT cycles.
